// File: rtl/haraka_s_ctrl_if.sv
// Handshake and core-facing bus of the Haraka-512 permutation controller.
// master = block producer/consumer and core side, slave = controller.
interface haraka_s_ctrl_if;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned JOBS_W = 16;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] core_in;
    logic              core_sel;
    logic [DATA_W-1:0] core_out;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic [JOBS_W-1:0] jobs_done;

    modport master (
        output in_valid, in_data, core_out, out_ready,
        input  in_ready, core_in, core_sel, out_valid, out_data, busy, jobs_done
    );

    modport slave (
        input  in_valid, in_data, core_out, out_ready,
        output in_ready, core_in, core_sel, out_valid, out_data, busy, jobs_done
    );
endinterface

// File: rtl/haraka_s_ctrl.sv
// Sequences a ROUNDS x LAT pipelined Haraka round core: loads a block, recirculates it,
// captures the final round into a one-entry output buffer.
module haraka_s_ctrl #(
    parameter int unsigned ROUNDS = 5,
    parameter int unsigned LAT    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    haraka_s_ctrl_if.slave   bus
);
    localparam int unsigned DATA_W = 512;
    localparam int unsigned JOBS_W = 16;
    localparam int unsigned TOTAL  = ROUNDS * LAT;
    localparam int unsigned CNT_W  = $clog2(TOTAL + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [JOBS_W-1:0]   jobs_done_q, jobs_done_d;
    logic                in_ready_c;
    logic                core_sel_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            jobs_done_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    // Accept only into an empty output buffer, so the core never has to stall.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        jobs_done_d = jobs_done_q;
        core_sel_c  = 1'b0;
        in_ready_c  = rst_n && (state_q == IDLE) && !out_valid_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.in_valid && in_ready_c) begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(1);
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(TOTAL)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.core_out;
                    jobs_done_d = jobs_done_q + JOBS_W'(1);
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    core_sel_c = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.core_sel  = core_sel_c;
    assign bus.core_in   = bus.in_data;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.jobs_done = jobs_done_q;
endmodule

// File: tb/tb_haraka_s_ctrl.sv
// Bench for haraka_s_ctrl: drives a stand-in pipelined round core and checks
// timing, data, backpressure, reset and counter behaviour.
module tb_haraka_s_ctrl;
    localparam int unsigned W      = 512;
    localparam int unsigned ROUNDS = 5;
    localparam int unsigned LAT    = 2;
    localparam int unsigned RL     = ROUNDS * LAT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    haraka_s_ctrl_if bus();
    haraka_s_ctrl_if bus_a();
    haraka_s_ctrl_if bus_b();

    haraka_s_ctrl #(.ROUNDS(ROUNDS), .LAT(LAT)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    haraka_s_ctrl #(.ROUNDS(1),      .LAT(1))   u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    haraka_s_ctrl #(.ROUNDS(5),      .LAT(3))   u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int n_vec = 0;
    int n_err = 0;

    // Stand-in round function; any fixed bijection-like mix exposes wrong capture timing.
    function automatic logic [W-1:0] rf(input logic [W-1:0] x);
        return {x[502:0], x[511:503]} ^ {16{32'h9E3779B9}} ^ {x[255:0], x[511:256]};
    endfunction

    function automatic logic [W-1:0] ref_perm(input logic [W-1:0] x);
        logic [W-1:0] v;
        v = x;
        for (int r = 0; r < int'(ROUNDS); r++) v = rf(v);
        return v;
    endfunction

    // Core model: LAT-deep pipeline, mux selects external input or feedback.
    logic [W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= rf(bus.core_sel ? pipe[LAT-1] : bus.core_in);
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign bus.core_out   = pipe[LAT-1];
    assign bus_a.core_out = {16{32'hA5A5A5A5}};
    assign bus_b.core_out = {16{32'h5A5A5A5A}};

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready"}, W'(bus.in_ready), W'(1));
    endtask

    // One job: accept, watch core_sel and latency, optionally stall the consumer.
    task automatic run_job(input logic [W-1:0] din, input int unsigned stall,
                           input logic [15:0] exp_jobs, input string tag);
        logic [63:0]  sel_got;
        logic [63:0]  sel_exp;
        int           lat;
        logic [W-1:0] held;
        logic         ok;
        wait_ready(tag);
        bus.in_valid  = 1'b1;
        bus.in_data   = din;
        bus.out_ready = (stall == 0);
        #1;
        chk({tag, " sel@T"}, W'(bus.core_sel), W'(0));
        chk({tag, " core_in"}, bus.core_in, din);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = {16{$urandom()}};
        sel_got = '0;
        lat     = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            sel_got[k] = bus.core_sel;
            if (bus.out_valid) lat = k;
        end
        sel_exp = ((64'd1 << RL) - 64'd1) & ~64'd1;
        chk({tag, " latency"}, W'(lat), W'(RL + 1));
        chk({tag, " sel pattern"}, W'(sel_got), W'(sel_exp));
        chk({tag, " out_data"}, bus.out_data, ref_perm(din));
        chk({tag, " jobs_done"}, W'(bus.jobs_done), W'(exp_jobs));
        chk({tag, " in_ready@valid"}, W'(bus.in_ready), W'(0));
        if (stall > 0) begin
            held = bus.out_data;
            ok   = 1'b1;
            repeat (stall) begin
                @(negedge clk);
                if (!bus.out_valid || bus.out_data !== held || bus.in_ready) ok = 1'b0;
            end
            chk({tag, " hold"}, W'(ok), W'(1));
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, " valid clr"}, W'(bus.out_valid), W'(0));
        chk({tag, " ready after"}, W'(bus.in_ready), W'(1));
    endtask

    typedef struct {
        logic [W-1:0] din;
        int unsigned  stall;
        logic [15:0]  exp_jobs;
    } vec_t;

    vec_t          vecs [4];
    logic [W-1:0]  ramp;
    logic [W-1:0]  blk [3];
    logic [W-1:0]  got_q [$];
    logic [63:0]   sel_a, sel_b;
    int            lat_a, lat_b, acc, sel_bad;
    logic          acc_now, ok;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        bus.in_valid    = 1'b0;  bus.in_data   = '0;  bus.out_ready   = 1'b1;
        bus_a.in_valid  = 1'b0;  bus_a.in_data = '0;  bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;  bus_b.in_data = '0;  bus_b.out_ready = 1'b1;
        for (int b = 0; b < 64; b++) ramp[8*(63-b) +: 8] = 8'(b);

        vecs[0] = '{ramp,                  0,  16'd1};
        vecs[1] = '{{W{1'b1}},             20, 16'd2};
        vecs[2] = '{{64{8'hA5}},           3,  16'd3};
        vecs[3] = '{{16{32'hDEADBEEF}},    1,  16'd4};

        #1;
        chk("rst in_ready",  W'(bus.in_ready),  W'(0));
        chk("rst out_valid", W'(bus.out_valid), W'(0));
        chk("rst out_data",  bus.out_data,      W'(0));
        chk("rst jobs_done", W'(bus.jobs_done), W'(0));
        chk("rst busy",      W'(bus.busy),      W'(0));
        chk("rst core_sel",  W'(bus.core_sel),  W'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready after rst", W'(bus.in_ready), W'(1));

        for (int i = 0; i < 4; i++) run_job(vecs[i].din, vecs[i].stall, vecs[i].exp_jobs, $sformatf("vec%0d", i));

        // Back-to-back with in_valid held high across three blocks.
        blk[0] = {16{32'h01234567}};
        blk[1] = {16{32'h89ABCDEF}};
        blk[2] = ramp ^ {W{1'b1}};
        acc = 0; sel_bad = 0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = blk[0];
        for (int c = 0; c < 100 && got_q.size() < 3; c++) begin
            if (bus.core_sel && !bus.busy) sel_bad++;
            if (bus.out_valid) got_q.push_back(bus.out_data);
            acc_now = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc_now) begin
                acc++;
                if (acc < 3) bus.in_data = blk[acc];
                else bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b count", W'(got_q.size()), W'(3));
        for (int i = 0; i < got_q.size() && i < 3; i++) chk($sformatf("b2b data%0d", i), got_q[i], ref_perm(blk[i]));
        chk("b2b sel idle", W'(sel_bad), W'(0));
        chk("b2b jobs_done", W'(bus.jobs_done), W'(7));

        // Reset while the job is at cnt=6.
        wait_ready("midrst");
        bus.in_valid = 1'b1;
        bus.in_data  = ramp;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", W'(bus.out_valid), W'(0));
        chk("midrst out_data",  bus.out_data,      W'(0));
        chk("midrst jobs_done", W'(bus.jobs_done), W'(0));
        chk("midrst busy",      W'(bus.busy),      W'(0));
        chk("midrst in_ready",  W'(bus.in_ready),  W'(0));
        chk("midrst core_sel",  W'(bus.core_sel),  W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) ok = 1'b0;
        end
        chk("midrst discarded", W'(ok), W'(1));
        run_job('0, 0, 16'd1, "zero");

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force u_dut.jobs_done_q = 16'hFFFF;
        #1;
        release u_dut.jobs_done_q;
        run_job(ramp, 0, 16'h0000, "wrap");

        // Parameter sweep instances started in the same cycle.
        @(negedge clk);
        chk("sweep ready", W'(bus_a.in_ready && bus_b.in_ready), W'(1));
        bus_a.in_valid = 1'b1;
        bus_b.in_valid = 1'b1;
        #1;
        chk("sweep sel@T", W'(bus_a.core_sel | bus_b.core_sel), W'(0));
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        sel_a = '0; sel_b = '0; lat_a = 0; lat_b = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            sel_a[k] = bus_a.core_sel;
            sel_b[k] = bus_b.core_sel;
            if (bus_a.out_valid && lat_a == 0) lat_a = k;
            if (bus_b.out_valid && lat_b == 0) lat_b = k;
        end
        chk("sweep 1x1 latency", W'(lat_a), W'(2));
        chk("sweep 1x1 sel",     W'(sel_a), W'(0));
        chk("sweep 5x3 latency", W'(lat_b), W'(16));
        chk("sweep 5x3 sel",     W'(sel_b), W'(((64'd1 << 15) - 64'd1) & ~64'd1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
